udp_ip_tx_framer: RTL and testbench

// - Builds UDP datagrams on top of the Ethernet stack's IP transmit interface.

---
 rtl/udp_ip_tx_framer.sv | 196 +++++++++++++++++++
 tb/tb_udp_ip_tx_framer.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_ip_tx_framer.sv
// UDP transmit framer: turns a UDP header request plus payload stream into an
// IP header handshake followed by the 8-byte UDP header and the payload bytes.
module udp_ip_tx_framer #(
    parameter logic [7:0]  IP_TTL      = 8'd64,
    parameter logic [5:0]  IP_DSCP     = 6'd0,
    parameter logic [1:0]  IP_ECN      = 2'd0,
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] local_ip,

    input  logic        s_udp_hdr_valid,
    output logic        s_udp_hdr_ready,
    input  logic [31:0] s_udp_dest_ip,
    input  logic [15:0] s_udp_source_port,
    input  logic [15:0] s_udp_dest_port,
    input  logic [15:0] s_udp_payload_length,
    input  logic [7:0]  s_udp_payload_axis_tdata,
    input  logic        s_udp_payload_axis_tvalid,
    output logic        s_udp_payload_axis_tready,
    input  logic        s_udp_payload_axis_tlast,
    input  logic        s_udp_payload_axis_tuser,

    output logic        m_ip_hdr_valid,
    input  logic        m_ip_hdr_ready,
    output logic [5:0]  m_ip_dscp,
    output logic [1:0]  m_ip_ecn,
    output logic [7:0]  m_ip_ttl,
    output logic [7:0]  m_ip_protocol,
    output logic [15:0] m_ip_length,
    output logic [31:0] m_ip_source_ip,
    output logic [31:0] m_ip_dest_ip,
    output logic [7:0]  m_ip_payload_axis_tdata,
    output logic        m_ip_payload_axis_tvalid,
    input  logic        m_ip_payload_axis_tready,
    output logic        m_ip_payload_axis_tlast,
    output logic        m_ip_payload_axis_tuser,

    output logic        error_oversize,
    output logic        error_length_mismatch
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        IDLE,
        IP_HDR,
        UDP_HDR,
        PAYLOAD,
        DROP
    } state_t;

    state_t      state;
    logic [2:0]  byte_idx;
    logic [15:0] remaining;
    logic [31:0] dest_ip_q;
    logic [15:0] src_port_q;
    logic [15:0] dst_port_q;
    logic [15:0] length_q;
    logic [15:0] udp_len;
    logic [7:0]  udp_hdr_byte;

    logic hdr_fire;
    logic in_fire;
    logic out_fire;

    assign hdr_fire = s_udp_hdr_valid && s_udp_hdr_ready;
    assign in_fire  = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready;
    assign out_fire = m_ip_payload_axis_tvalid && m_ip_payload_axis_tready;

    assign udp_len        = length_q + 16'd8;
    assign m_ip_dscp      = IP_DSCP;
    assign m_ip_ecn       = IP_ECN;
    assign m_ip_ttl       = IP_TTL;
    assign m_ip_protocol  = 8'd17;
    assign m_ip_length    = length_q + 16'd28;
    assign m_ip_source_ip = local_ip;
    assign m_ip_dest_ip   = dest_ip_q;

    always_comb begin
        udp_hdr_byte = 8'h00;
        case (byte_idx)
            3'd0:    udp_hdr_byte = src_port_q[15:8];
            3'd1:    udp_hdr_byte = src_port_q[7:0];
            3'd2:    udp_hdr_byte = dst_port_q[15:8];
            3'd3:    udp_hdr_byte = dst_port_q[7:0];
            3'd4:    udp_hdr_byte = udp_len[15:8];
            3'd5:    udp_hdr_byte = udp_len[7:0];
            default: udp_hdr_byte = 8'h00;
        endcase
    end

    // Handshake outputs are gated by rst so nothing leaks out while reset is held.
    always_comb begin
        s_udp_hdr_ready           = (state == IDLE) && !rst;
        m_ip_hdr_valid            = (state == IP_HDR) && !rst;
        s_udp_payload_axis_tready = 1'b0;
        m_ip_payload_axis_tdata   = 8'h00;
        m_ip_payload_axis_tvalid  = 1'b0;
        m_ip_payload_axis_tlast   = 1'b0;
        m_ip_payload_axis_tuser   = 1'b0;
        case (state)
            UDP_HDR: begin
                m_ip_payload_axis_tvalid = !rst;
                m_ip_payload_axis_tdata  = udp_hdr_byte;
                m_ip_payload_axis_tlast  = (byte_idx == 3'd7) && (length_q == 16'd0);
            end
            PAYLOAD: begin
                m_ip_payload_axis_tdata   = s_udp_payload_axis_tdata;
                m_ip_payload_axis_tvalid  = s_udp_payload_axis_tvalid && !rst;
                s_udp_payload_axis_tready = m_ip_payload_axis_tready && !rst;
                if (s_udp_payload_axis_tlast || remaining == 16'd1) begin
                    m_ip_payload_axis_tlast = 1'b1;
                    m_ip_payload_axis_tuser = (s_udp_payload_axis_tlast && remaining == 16'd1)
                                              ? s_udp_payload_axis_tuser : 1'b1;
                end
            end
            DROP: begin
                s_udp_payload_axis_tready = !rst;
            end
            default: begin
            end
        endcase
    end

    // Main sequencer; any length disagreement ends the output frame with tuser set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            byte_idx              <= 3'd0;
            remaining             <= 16'd0;
            error_oversize        <= 1'b0;
            error_length_mismatch <= 1'b0;
        end else begin
            error_oversize        <= 1'b0;
            error_length_mismatch <= 1'b0;
            case (state)
                IDLE: begin
                    if (hdr_fire) begin
                        dest_ip_q  <= s_udp_dest_ip;
                        src_port_q <= s_udp_source_port;
                        dst_port_q <= s_udp_dest_port;
                        length_q   <= s_udp_payload_length;
                        if (s_udp_payload_length > MAX_LEN) begin
                            error_oversize <= 1'b1;
                            state          <= DROP;
                        end else begin
                            state <= IP_HDR;
                        end
                    end
                end
                IP_HDR: begin
                    if (m_ip_hdr_ready) begin
                        byte_idx <= 3'd0;
                        state    <= UDP_HDR;
                    end
                end
                UDP_HDR: begin
                    if (out_fire) begin
                        byte_idx <= byte_idx + 3'd1;
                        if (byte_idx == 3'd7) begin
                            if (length_q == 16'd0) begin
                                state <= IDLE;
                            end else begin
                                remaining <= length_q;
                                state     <= PAYLOAD;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    if (in_fire) begin
                        remaining <= remaining - 16'd1;
                        if (s_udp_payload_axis_tlast) begin
                            if (remaining != 16'd1) begin
                                error_length_mismatch <= 1'b1;
                            end
                            state <= IDLE;
                        end else if (remaining == 16'd1) begin
                            error_length_mismatch <= 1'b1;
                            state                 <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (in_fire && s_udp_payload_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_ip_tx_framer.sv
// Randomized bench for udp_ip_tx_framer: each datagram's expected output is
// derived from the request and input byte list, then compared to what was seen.
module tb_udp_ip_tx_framer;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8_0001;
    localparam int BUDGET = 4000;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] len;
        logic [31:0] src;
        logic [31:0] dst;
    } ip_hdr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_udp_hdr_valid = 1'b0;
    logic        s_udp_hdr_ready;
    logic [31:0] s_udp_dest_ip = '0;
    logic [15:0] s_udp_source_port = '0;
    logic [15:0] s_udp_dest_port = '0;
    logic [15:0] s_udp_payload_length = '0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        m_ip_hdr_valid;
    logic        m_ip_hdr_ready = 1'b1;
    logic [5:0]  m_ip_dscp;
    logic [1:0]  m_ip_ecn;
    logic [7:0]  m_ip_ttl;
    logic [7:0]  m_ip_protocol;
    logic [15:0] m_ip_length;
    logic [31:0] m_ip_source_ip;
    logic [31:0] m_ip_dest_ip;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic        m_tuser;
    logic        error_oversize;
    logic        error_length_mismatch;

    int tests_run = 0;
    int tests_failed = 0;
    bit stall = 1'b0;
    int cycle = 0;

    logic [9:0] out_q[$];
    ip_hdr_t    hdr_q[$];
    int         accept_cyc[$];
    int         ovs_cnt = 0;
    int         mm_cnt = 0;
    int         tready_cnt = 0;

    logic       prev_t_stall = 1'b0;
    logic [8:0] prev_t_beat = '0;
    logic       prev_h_stall = 1'b0;
    ip_hdr_t    prev_h = '0;

    udp_ip_tx_framer #(
        .IP_TTL(8'd64),
        .IP_DSCP(6'd0),
        .IP_ECN(2'd0),
        .MAX_PAYLOAD(1472)
    ) dut (
        .clk(clk),
        .rst(rst),
        .local_ip(LOCAL_IP),
        .s_udp_hdr_valid(s_udp_hdr_valid),
        .s_udp_hdr_ready(s_udp_hdr_ready),
        .s_udp_dest_ip(s_udp_dest_ip),
        .s_udp_source_port(s_udp_source_port),
        .s_udp_dest_port(s_udp_dest_port),
        .s_udp_payload_length(s_udp_payload_length),
        .s_udp_payload_axis_tdata(s_tdata),
        .s_udp_payload_axis_tvalid(s_tvalid),
        .s_udp_payload_axis_tready(s_tready),
        .s_udp_payload_axis_tlast(s_tlast),
        .s_udp_payload_axis_tuser(s_tuser),
        .m_ip_hdr_valid(m_ip_hdr_valid),
        .m_ip_hdr_ready(m_ip_hdr_ready),
        .m_ip_dscp(m_ip_dscp),
        .m_ip_ecn(m_ip_ecn),
        .m_ip_ttl(m_ip_ttl),
        .m_ip_protocol(m_ip_protocol),
        .m_ip_length(m_ip_length),
        .m_ip_source_ip(m_ip_source_ip),
        .m_ip_dest_ip(m_ip_dest_ip),
        .m_ip_payload_axis_tdata(m_tdata),
        .m_ip_payload_axis_tvalid(m_tvalid),
        .m_ip_payload_axis_tready(m_tready),
        .m_ip_payload_axis_tlast(m_tlast),
        .m_ip_payload_axis_tuser(m_tuser),
        .error_oversize(error_oversize),
        .error_length_mismatch(error_length_mismatch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall) begin
                m_tready       = ($urandom % 3) != 0;
                m_ip_hdr_ready = ($urandom % 3) != 0;
            end else begin
                m_tready       = 1'b1;
                m_ip_hdr_ready = 1'b1;
            end
        end
    end

    // Handshakes happen on the next posedge, so the negedge view is what gets transferred.
    always @(negedge clk) begin
        ip_hdr_t cur_h;
        cur_h = '{m_ip_dscp, m_ip_ecn, m_ip_ttl, m_ip_protocol, m_ip_length, m_ip_source_ip, m_ip_dest_ip};
        if (!rst) begin
            if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tuser, m_tdata});
            if (m_ip_hdr_valid && m_ip_hdr_ready) hdr_q.push_back(cur_h);
            if (error_oversize) ovs_cnt++;
            if (error_length_mismatch) mm_cnt++;
            if (s_tready) tready_cnt++;
            if (s_udp_hdr_valid && s_udp_hdr_ready) accept_cyc.push_back(cycle);
            if (prev_t_stall) begin
                tests_run++;
                if (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== prev_t_beat) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_hold_tdata: got valid=%b beat=%h, need valid=1 beat=%h",
                             m_tvalid, {m_tlast, m_tdata}, prev_t_beat);
                end
            end
            if (prev_h_stall) begin
                tests_run++;
                if (m_ip_hdr_valid !== 1'b1 || cur_h !== prev_h) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_hold_iphdr: got valid=%b hdr=%h, need valid=1 hdr=%h",
                             m_ip_hdr_valid, cur_h, prev_h);
                end
            end
        end
        prev_t_stall = !rst && m_tvalid && !m_tready;
        prev_t_beat  = {m_tlast, m_tdata};
        prev_h_stall = !rst && m_ip_hdr_valid && !m_ip_hdr_ready;
        prev_h       = cur_h;
    end

    task automatic drive_header(input logic [15:0] sp, input logic [15:0] dp,
                                input logic [31:0] dip, input logic [15:0] len);
        int n = 0;
        logic ok;
        s_udp_hdr_valid      = 1'b1;
        s_udp_source_port    = sp;
        s_udp_dest_port      = dp;
        s_udp_dest_ip        = dip;
        s_udp_payload_length = len;
        do begin
            @(negedge clk);
            ok = s_udp_hdr_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < BUDGET);
        s_udp_hdr_valid = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL hdr_timeout: got no s_udp_hdr_ready, need one within %0d cycles", BUDGET);
        end
    endtask

    task automatic drive_payload(input byte_q_t data, input logic tuser_last, input bit gaps);
        logic ok;
        int n;
        foreach (data[i]) begin
            if (gaps && ($urandom % 4) == 0) begin
                s_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_tvalid = 1'b1;
            s_tdata  = data[i];
            s_tlast  = (i == data.size() - 1);
            s_tuser  = (i == data.size() - 1) ? tuser_last : 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                ok = s_tready;
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < BUDGET);
            if (!ok) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL payload_timeout: got no tready on byte %0d, need one within %0d cycles", i, BUDGET);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_udp_hdr_ready && n < BUDGET);
        if (!s_udp_hdr_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL idle_timeout: got hdr_ready=0, need 1 within %0d cycles", BUDGET);
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Expected stream: 8 header bytes, then min(len, sent) payload bytes, the last one flagged.
    task automatic run_datagram(input string name, input logic [15:0] sp, input logic [15:0] dp,
                                input logic [31:0] dip, input int len, input int nin,
                                input logic tuser_last);
        byte_q_t    pl;
        logic [9:0] exp_q[$];
        logic [7:0] hb[8];
        int         nout;
        int         exp_mm;
        bit         oversize;
        logic [15:0] ulen;
        ip_hdr_t    exp_h;
        logic       last;
        out_q.delete();
        hdr_q.delete();
        ovs_cnt = 0;
        mm_cnt = 0;
        tready_cnt = 0;
        oversize = len > 1472;
        for (int i = 0; i < nin; i++) pl.push_back(8'($urandom));
        ulen = 16'(len + 8);
        hb = '{sp[15:8], sp[7:0], dp[15:8], dp[7:0], ulen[15:8], ulen[7:0], 8'h00, 8'h00};
        if (!oversize) begin
            for (int i = 0; i < 8; i++) exp_q.push_back({(len == 0 && i == 7), 1'b0, hb[i]});
            nout = (nin < len) ? nin : len;
            for (int i = 0; i < nout; i++) begin
                last = (i == nout - 1);
                exp_q.push_back({last, last ? ((nin == len) ? tuser_last : 1'b1) : 1'b0, pl[i]});
            end
        end
        exp_mm = (!oversize && len != 0 && nin != len) ? 1 : 0;
        exp_h  = '{6'd0, 2'd0, 8'd64, 8'd17, 16'(len + 28), LOCAL_IP, dip};

        fork
            drive_header(sp, dp, dip, 16'(len));
            if (nin > 0) drive_payload(pl, tuser_last, stall);
        join
        wait_idle();

        tests_run++;
        if (out_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("[TB] FAIL %s beat_count: got %0d, need %0d", name, out_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests_run++;
                if ({out_q[i][9], out_q[i][7:0]} !== {exp_q[i][9], exp_q[i][7:0]} ||
                    (exp_q[i][9] && out_q[i][8] !== exp_q[i][8])) begin
                    tests_failed++;
                    $display("[TB] FAIL %s beat%0d {tlast,tuser,data}: got %h, need %h",
                             name, i, out_q[i], exp_q[i]);
                    break;
                end
            end
        end
        tests_run++;
        if (hdr_q.size() != (oversize ? 0 : 1)) begin
            tests_failed++;
            $display("[TB] FAIL %s ip_hdr_count: got %0d, need %0d", name, hdr_q.size(), oversize ? 0 : 1);
        end else if (!oversize) begin
            tests_run++;
            if (hdr_q[0] !== exp_h) begin
                tests_failed++;
                $display("[TB] FAIL %s ip_hdr_fields: got %h, need %h", name, hdr_q[0], exp_h);
            end
        end
        tests_run++;
        if (ovs_cnt != (oversize ? 1 : 0)) begin
            tests_failed++;
            $display("[TB] FAIL %s error_oversize_pulses: got %0d, need %0d", name, ovs_cnt, oversize ? 1 : 0);
        end
        tests_run++;
        if (mm_cnt != exp_mm) begin
            tests_failed++;
            $display("[TB] FAIL %s error_length_mismatch_pulses: got %0d, need %0d", name, mm_cnt, exp_mm);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({m_ip_hdr_valid, m_tvalid, s_udp_hdr_ready, s_tready} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_held {hdr_valid,tvalid,hdr_ready,tready}: got %b, need 0000",
                     {m_ip_hdr_valid, m_tvalid, s_udp_hdr_ready, s_tready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({m_ip_hdr_valid, m_tvalid, error_oversize, error_length_mismatch, s_udp_hdr_ready} !== 5'b00001) begin
            tests_failed++;
            $display("[TB] FAIL reset_release {hdr_valid,tvalid,err_ovs,err_mm,hdr_ready}: got %b, need 00001",
                     {m_ip_hdr_valid, m_tvalid, error_oversize, error_length_mismatch, s_udp_hdr_ready});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        stall = 1'b0;
        run_datagram("basic_len4", 16'h1234, 16'h5678, 32'h0A00_0002, 4, 4, 1'b0);
        run_datagram("basic_tuser", 16'h0400, 16'h0035, 32'h0A00_0003, 9, 9, 1'b1);
    endtask

    task automatic test_len_zero();
        stall = 1'b0;
        run_datagram("len_zero", 16'hABCD, 16'h0007, 32'h0A00_0004, 0, 0, 1'b0);
        tests_run++;
        if (tready_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL len_zero_tready: got %0d cycles with tready, need 0", tready_cnt);
        end
    endtask

    task automatic test_length_errors();
        stall = 1'b0;
        run_datagram("early_end", 16'h1111, 16'h2222, 32'h0A00_0005, 5, 3, 1'b0);
        run_datagram("after_early", 16'h3333, 16'h4444, 32'h0A00_0006, 2, 2, 1'b0);
        run_datagram("overrun", 16'h5555, 16'h6666, 32'h0A00_0007, 2, 6, 1'b0);
        run_datagram("after_overrun", 16'h7777, 16'h8888, 32'h0A00_0008, 3, 3, 1'b0);
    endtask

    task automatic test_oversize();
        stall = 1'b0;
        run_datagram("oversize", 16'h9999, 16'hAAAA, 32'h0A00_0009, 1473, 5, 1'b0);
        run_datagram("max_payload", 16'hBBBB, 16'hCCCC, 32'h0A00_000A, 1472, 1472, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lens[3] = '{4, 0, 7};
        int total = 0;
        stall = 1'b0;
        out_q.delete();
        hdr_q.delete();
        accept_cyc.delete();
        fork
            begin
                for (int k = 0; k < 3; k++) drive_header(16'(k + 1), 16'(k + 100), 32'h0A00_0010, 16'(lens[k]));
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    byte_q_t pl;
                    for (int i = 0; i < lens[k]; i++) pl.push_back(8'($urandom));
                    if (lens[k] > 0) drive_payload(pl, 1'b0, 1'b0);
                end
            end
        join
        wait_idle();
        for (int k = 0; k < 3; k++) total += 8 + lens[k];
        tests_run++;
        if (out_q.size() != total || hdr_q.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_counts: got beats=%0d hdrs=%0d, need beats=%0d hdrs=3",
                     out_q.size(), hdr_q.size(), total);
        end
        tests_run++;
        if (accept_cyc.size() != 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_accepts: got %0d header accepts, need 3", accept_cyc.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (accept_cyc[k + 1] - accept_cyc[k] != lens[k] + 10) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_gap%0d: got %0d cycles, need %0d",
                             k, accept_cyc[k + 1] - accept_cyc[k], lens[k] + 10);
                end
            end
        end
    endtask

    task automatic test_reset_mid_payload();
        logic ok;
        int n;
        int tlast_seen = 0;
        stall = 1'b0;
        out_q.delete();
        drive_header(16'hDEAD, 16'hBEEF, 32'h0A00_0020, 16'd10);
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(i + 8'h40);
            s_tlast  = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                ok = s_tready;
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < BUDGET);
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if ({m_ip_hdr_valid, m_tvalid, s_udp_hdr_ready, s_tready} !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL mid_rst_held {hdr_valid,tvalid,hdr_ready,tready}: got %b, need 0000",
                         {m_ip_hdr_valid, m_tvalid, s_udp_hdr_ready, s_tready});
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({m_ip_hdr_valid, m_tvalid} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL mid_rst_after {hdr_valid,tvalid}: got %b, need 00", {m_ip_hdr_valid, m_tvalid});
        end
        foreach (out_q[i]) if (out_q[i][9]) tlast_seen++;
        tests_run++;
        if (out_q.size() != 11 || tlast_seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL mid_rst_partial: got beats=%0d tlasts=%0d, need beats=11 tlasts=0",
                     out_q.size(), tlast_seen);
        end
        @(posedge clk);
        #1;
        run_datagram("after_rst", 16'h0102, 16'h0304, 32'h0A00_0021, 6, 6, 1'b0);
    endtask

    task automatic test_random_stalls();
        int mode, len, nin;
        stall = 1'b1;
        for (int t = 0; t < 25; t++) begin
            mode = int'($urandom % 6);
            case (mode)
                0: begin len = 0; nin = 0; end
                1: begin len = 1473 + int'($urandom % 100); nin = 1 + int'($urandom % 6); end
                2: begin len = 3 + int'($urandom % 20); nin = 1 + int'($urandom % (len - 1)); end
                3: begin len = 1 + int'($urandom % 10); nin = len + 1 + int'($urandom % 4); end
                default: begin len = 1 + int'($urandom % 30); nin = len; end
            endcase
            run_datagram($sformatf("rand%0d", t), 16'($urandom), 16'($urandom), $urandom, len, nin,
                         1'($urandom % 2));
        end
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_length_errors();
        test_oversize();
        test_back_to_back();
        test_reset_mid_payload();
        test_random_stalls();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
